knap11_search: RTL and testbench
================================

Name: knap11_search

Overview:
- Sequential enumerator and solver for the 11-item, 3-constraint knapsack instance: value, weight and volume per item.
- Generates every candidate selection vector, evaluates it and streams each valid selection out over a ready/valid interface.
- Reports the best-value selection and the count of valid selections when the sweep finishes.
- Sits upstream of anything that consumes solutions; it is the producer side of the selection-vector interface whose consumer side is the combinational validity check.

Parameters:
- MIN_VALUE, 107, minimum total value (inclusive) for a valid selection
- MAX_WEIGHT, 60, maximum total weight (inclusive)
- MAX_VOLUME, 60, maximum total volume (inclusive)
- SUM_W, 10, width of the internal total accumulators; no modular wrap is permitted

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a sweep; ignored unless state is IDLE or DONE
- busy  out  1  high in RUN and DRAIN
- sol_valid  out  1  a valid selection is presented
- sol_ready  in  1  consumer accepts the presented selection
- sol_sel  out  11  presented selection; bit0=A … bit10=K
- sol_value  out  SUM_W  total value of sol_sel
- done  out  1  one-cycle pulse when the sweep completes
- found  out  1  at least one valid selection seen; held until next start
- best_sel  out  11  highest-value valid selection; held until next start
- best_value  out  SUM_W  value of best_sel
- sol_count  out  12  number of valid selections (0..2048)

Behaviour:
- Reset: every output is 0 and the state is IDLE. Asserting rst_n low mid-sweep aborts immediately and emits no done.
- States and transitions:
  - IDLE -> RUN on start. At that point: cand=0, found/best/sol_count cleared, pipeline emptied.
  - RUN: one candidate per cycle enters stage 1, in ascending order 0..2047. After issuing 2047 -> DRAIN.
  - DRAIN: wait until both pipeline stages are empty and sol_valid is low -> DONE.
  - DONE: done=1 for exactly one cycle, then stay in DONE with the results held. start -> RUN.
- Pipeline:
  - Stage 1 registers cand together with the zero-extended SUM_W-bit totals from sub-module knap11_eval.
  - Stage 2 registers the compare result: value>=MIN_VALUE, weight<=MAX_WEIGHT, volume<=MAX_VOLUME.
  - A valid stage-2 entry loads the output register (sol_valid=1), increments sol_count, and updates best when value > best_value or found==0. The comparison is strict, so ties keep the lower-indexed selection.
- Handshake:
  - Transfer happens when sol_valid && sol_ready.
  - sol_sel and sol_value must stay stable while sol_valid && !sol_ready.
  - While stalled (sol_valid && !sol_ready), the whole pipeline and the candidate counter freeze. No candidate is skipped or duplicated.
  - sol_valid may rise in the same cycle as a transfer, so back-to-back solutions run at one per cycle.
- Counter boundaries: cand is 12 bits wide and its terminal value is 2047. No wrap back to 0 is allowed inside a sweep. sol_count saturates at 2048 by construction.
- Latency: with sol_ready held at 1, done pulses exactly 2051 cycles after the cycle in which start is sampled.
- start during RUN or DRAIN is ignored and does not restart the sweep.
- A start in the same cycle as done is accepted: results clear and a new sweep begins.

Decomposition:
- Package knap11_pkg holds:
  - N_ITEMS=11
  - Item tables as constant arrays indexed A..K:
    - value {4,8,0,20,10,12,18,14,6,15,30}
    - weight {28,8,27,18,27,28,6,1,20,0,5}
    - volume {27,27,4,4,0,24,4,20,12,15,5}
  - A state enum {IDLE,RUN,DRAIN,DONE}
- Sub-module knap11_eval: combinational sel[10:0] -> three SUM_W totals. It is reused by the bench as its reference model.

Test Plan:
- Default parameters, sol_ready=1, start pulse -> stream contains sel 0x6D8 (K,J,H,G,E,D; value 107, weight 57, volume 48). found=1 and done arrives at cycle 2051.
- MIN_VALUE=0, MAX_WEIGHT=0, MAX_VOLUME=0 -> exactly one solution sel 0x000, sol_count=1, best_sel=0x000, best_value=0.
- MIN_VALUE=0, MAX_WEIGHT=255, MAX_VOLUME=255 -> sol_count=2048 and best_value=137. Tie-break gives best_sel=0x7FB, not 0x7FF.
- Default parameters with sol_ready randomly 30% low -> the solution sequence matches the sol_ready=1 run exactly, and sol_sel holds stable during stalls.
- MIN_VALUE=200 -> no sol_valid ever, found=0, sol_count=0, done still pulses at cycle 2051.
- rst_n low at cycle 1000 of a sweep -> all outputs 0 asynchronously, no done. A new start then runs a full clean sweep.

Source files
------------

// File: rtl/knap11_search_pkg.sv
// knap11_pkg: item tables, sizes and FSM states for the 11-item knapsack search
package knap11_pkg;
  localparam int N_ITEMS = 11;
  localparam int CAND_W = 12;
  localparam logic [CAND_W-1:0] LAST_CAND = 12'd2047;
  typedef logic [N_ITEMS-1:0] sel_t;
  localparam logic [7:0] ITEM_VALUE [N_ITEMS] = '{8'd4, 8'd8, 8'd0, 8'd20, 8'd10, 8'd12, 8'd18, 8'd14, 8'd6, 8'd15, 8'd30};
  localparam logic [7:0] ITEM_WEIGHT [N_ITEMS] = '{8'd28, 8'd8, 8'd27, 8'd18, 8'd27, 8'd28, 8'd6, 8'd1, 8'd20, 8'd0, 8'd5};
  localparam logic [7:0] ITEM_VOLUME [N_ITEMS] = '{8'd27, 8'd27, 8'd4, 8'd4, 8'd0, 8'd24, 8'd4, 8'd20, 8'd12, 8'd15, 8'd5};
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/knap11_search_if.sv
// knap11_search_if: ready/valid stream of valid selections with their total value
interface knap11_search_if import knap11_pkg::*; #(parameter int SUM_W = 10);
  logic sol_valid;
  logic sol_ready;
  sel_t sol_sel;
  logic [SUM_W-1:0] sol_value;
  modport master (output sol_valid, sol_sel, sol_value, input sol_ready);
  modport slave (input sol_valid, sol_sel, sol_value, output sol_ready);
endinterface

// File: rtl/knap11_search_eval.sv
// knap11_eval: combinational value/weight/volume totals of one selection vector
module knap11_eval import knap11_pkg::*; #(parameter int SUM_W = 10) (
  input  sel_t             sel,
  output logic [SUM_W-1:0] value,
  output logic [SUM_W-1:0] weight,
  output logic [SUM_W-1:0] volume
);
  // Sum the table entries of every selected item
  always_comb begin
    value = '0;
    weight = '0;
    volume = '0;
    for (int i = 0; i < N_ITEMS; i++)
      if (sel[i]) begin
        value = value + SUM_W'(ITEM_VALUE[i]);
        weight = weight + SUM_W'(ITEM_WEIGHT[i]);
        volume = volume + SUM_W'(ITEM_VOLUME[i]);
      end
  end
endmodule

// File: rtl/knap11_search.sv
// knap11_search: sweeps all 2048 selections, streams the valid ones and tracks the best
module knap11_search import knap11_pkg::*; #(
  parameter int MIN_VALUE  = 107,
  parameter int MAX_WEIGHT = 60,
  parameter int MAX_VOLUME = 60,
  parameter int SUM_W      = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  knap11_search_if.master    sol,
  output logic               done,
  output logic               found,
  output sel_t               best_sel,
  output logic [SUM_W-1:0]   best_value,
  output logic [11:0]        sol_count
);
  localparam logic [SUM_W-1:0] MIN_V = SUM_W'(MIN_VALUE);
  localparam logic [SUM_W-1:0] MAX_W = SUM_W'(MAX_WEIGHT);
  localparam logic [SUM_W-1:0] MAX_U = SUM_W'(MAX_VOLUME);
  state_t state, state_n;
  logic [CAND_W-1:0] cand;
  logic stall, go, issue, last;
  logic s1_v;
  sel_t s1_sel;
  logic [SUM_W-1:0] s1_val, s1_wt, s1_vol;
  logic [SUM_W-1:0] e_val, e_wt, e_vol;
  logic s2_v, s2_ok;
  sel_t s2_sel;
  logic [SUM_W-1:0] s2_val;
  assign stall = sol.sol_valid && !sol.sol_ready;
  assign go = start && (state == IDLE || state == DONE);
  assign issue = state == RUN && !stall;
  assign last = cand == LAST_CAND;
  assign busy = state == RUN || state == DRAIN;
  knap11_eval #(.SUM_W(SUM_W)) u_eval (
    .sel    (cand[N_ITEMS-1:0]),
    .value  (e_val),
    .weight (e_wt),
    .volume (e_vol)
  );
  // Next state: start only matters when idle or finished; drain waits until the output frees up
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: state_n = start ? RUN : state;
      RUN:        state_n = issue && last ? DRAIN : RUN;
      DRAIN:      state_n = !s1_v && !s2_v && !stall ? DONE : DRAIN;
      default:    state_n = IDLE;
    endcase
  end
  // State register; done pulses on the single cycle after entering DONE
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      done <= 1'b0;
    end else begin
      state <= state_n;
      done <= state_n == DONE && state != DONE;
    end
  // Candidate counter; parks at the terminal value instead of wrapping
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cand <= '0;
    else if (go) cand <= '0;
    else if (issue && !last) cand <= cand + CAND_W'(1);
  // Evaluate/compare pipeline and output register, all frozen while the consumer stalls
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_v <= 1'b0;
      s1_sel <= '0;
      s1_val <= '0;
      s1_wt <= '0;
      s1_vol <= '0;
      s2_v <= 1'b0;
      s2_ok <= 1'b0;
      s2_sel <= '0;
      s2_val <= '0;
      sol.sol_valid <= 1'b0;
      sol.sol_sel <= '0;
      sol.sol_value <= '0;
    end else if (go) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s2_ok <= 1'b0;
      sol.sol_valid <= 1'b0;
    end else if (!stall) begin
      s1_v <= issue;
      s1_sel <= cand[N_ITEMS-1:0];
      s1_val <= e_val;
      s1_wt <= e_wt;
      s1_vol <= e_vol;
      s2_v <= s1_v;
      s2_ok <= s1_v && s1_val >= MIN_V && s1_wt <= MAX_W && s1_vol <= MAX_U;
      s2_sel <= s1_sel;
      s2_val <= s1_val;
      sol.sol_valid <= s2_ok;
      if (s2_ok) begin
        sol.sol_sel <= s2_sel;
        sol.sol_value <= s2_val;
      end
    end
  // Count and best-so-far; strict compare keeps the earliest of equal-value selections
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      found <= 1'b0;
      best_sel <= '0;
      best_value <= '0;
      sol_count <= '0;
    end else if (go) begin
      found <= 1'b0;
      best_sel <= '0;
      best_value <= '0;
      sol_count <= '0;
    end else if (!stall && s2_ok) begin
      found <= 1'b1;
      sol_count <= sol_count + 12'd1;
      if (!found || s2_val > best_value) begin
        best_sel <= s2_sel;
        best_value <= s2_val;
      end
    end
endmodule

// File: tb/tb_knap11_search.sv
// tb_knap11_search: directed checks of the knapsack sweep over four parameter sets
module tb_knap11_search;
  import knap11_pkg::*;
  typedef struct { int sel; int v; int w; int u; } ev_t;
  typedef struct { int f; int bs; int bv; int cnt; } res_t;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic busy [4], done [4], found [4];
  sel_t bsel [4];
  logic [9:0] bval [4];
  logic [11:0] cnt [4];
  sel_t ev_sel;
  logic [9:0] ev_v, ev_w, ev_u;
  int tests = 0, fails = 0;
  int q0 [$], exp0 [$];
  int n1 = 0, s1 = 0, v3 = 0, herr = 0, dseen = 0;
  int m_bs = 0, m_bv = 0, m_cnt = 0;
  int d [4];
  bit rnd = 0, hold = 0, got = 0;
  sel_t hsel;
  logic [9:0] hval;
  ev_t ev [9];
  res_t res [4];

  always #5 clk = ~clk;

  knap11_search_if #(.SUM_W(10)) i0 (), i1 (), i2 (), i3 ();

  knap11_search u0 (.clk(clk), .rst_n(rst_n), .start(start), .busy(busy[0]), .sol(i0), .done(done[0]),
    .found(found[0]), .best_sel(bsel[0]), .best_value(bval[0]), .sol_count(cnt[0]));
  knap11_search #(.MIN_VALUE(0), .MAX_WEIGHT(0), .MAX_VOLUME(0)) u1 (.clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy[1]), .sol(i1), .done(done[1]), .found(found[1]), .best_sel(bsel[1]), .best_value(bval[1]), .sol_count(cnt[1]));
  knap11_search #(.MIN_VALUE(0), .MAX_WEIGHT(255), .MAX_VOLUME(255)) u2 (.clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy[2]), .sol(i2), .done(done[2]), .found(found[2]), .best_sel(bsel[2]), .best_value(bval[2]), .sol_count(cnt[2]));
  knap11_search #(.MIN_VALUE(200)) u3 (.clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy[3]), .sol(i3), .done(done[3]), .found(found[3]), .best_sel(bsel[3]), .best_value(bval[3]), .sol_count(cnt[3]));
  knap11_eval #(.SUM_W(10)) u_ev (.sel(ev_sel), .value(ev_v), .weight(ev_w), .volume(ev_u));

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int tot(input int s, input int k);
    int t = 0;
    for (int i = 0; i < N_ITEMS; i++)
      if (s[i]) t += k == 0 ? int'(ITEM_VALUE[i]) : k == 1 ? int'(ITEM_WEIGHT[i]) : int'(ITEM_VOLUME[i]);
    return t;
  endfunction

  task automatic chk_stream(input string nm);
    int mism = 0, hit = 0;
    chk({nm, " stream length"}, q0.size(), exp0.size());
    foreach (q0[i]) begin
      if (i < exp0.size() && q0[i] != exp0[i]) mism++;
      if (q0[i] == 107 * 2048 + 'h6D8) hit = 1;
    end
    chk({nm, " stream order"}, mism, 0);
    chk({nm, " stream has 0x6D8"}, hit, 1);
  endtask

  task automatic chk_res(input string nm, input int k);
    chk($sformatf("%s u%0d found", nm, k), int'(found[k]), res[k].f);
    chk($sformatf("%s u%0d best_sel", nm, k), int'(bsel[k]), res[k].bs);
    chk($sformatf("%s u%0d best_value", nm, k), int'(bval[k]), res[k].bv);
    chk($sformatf("%s u%0d sol_count", nm, k), int'(cnt[k]), res[k].cnt);
  endtask

  task automatic sweep(input int lim);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    d = '{0, 0, 0, 0};
    for (int n = 1; n <= lim && (d[0] == 0 || d[1] == 0 || d[2] == 0 || d[3] == 0); n++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) if (done[k] && d[k] == 0) d[k] = n;
    end
  endtask

  always @(negedge clk) begin
    if (i0.sol_valid && i0.sol_ready) q0.push_back(int'(i0.sol_value) * 2048 + int'(i0.sol_sel));
    if (i1.sol_valid && i1.sol_ready) begin
      n1++;
      s1 = int'(i1.sol_sel);
    end
    if (i3.sol_valid) v3++;
    if (hold && (!i0.sol_valid || i0.sol_sel != hsel || i0.sol_value != hval)) herr++;
    hold = i0.sol_valid && !i0.sol_ready;
    hsel = i0.sol_sel;
    hval = i0.sol_value;
    if (done[0]) dseen++;
  end

  initial begin
    i0.sol_ready = 1'b1;
    i1.sol_ready = 1'b1;
    i2.sol_ready = 1'b1;
    i3.sol_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      i0.sol_ready = rnd ? ($urandom_range(0, 9) >= 3) : 1'b1;
    end
  end

  initial begin
    ev[0] = '{'h000, 0, 0, 0};
    ev[1] = '{'h001, 4, 28, 27};
    ev[2] = '{'h400, 30, 5, 5};
    ev[3] = '{'h6D8, 107, 57, 48};
    ev[4] = '{'h7FF, 137, 168, 142};
    ev[5] = '{'h7FB, 137, 141, 138};
    ev[6] = '{'h004, 0, 27, 4};
    ev[7] = '{'h0A0, 26, 29, 44};
    ev[8] = '{'h300, 21, 20, 27};
    for (int s = 0; s < 2048; s++)
      if (tot(s, 0) >= 107 && tot(s, 1) <= 60 && tot(s, 2) <= 60) begin
        exp0.push_back(tot(s, 0) * 2048 + s);
        if (m_cnt == 0 || tot(s, 0) > m_bv) begin
          m_bs = s;
          m_bv = tot(s, 0);
        end
        m_cnt++;
      end
    res[0] = '{1, m_bs, m_bv, m_cnt};
    res[1] = '{1, 0, 0, 1};
    res[2] = '{1, 'h7FB, 137, 2048};
    res[3] = '{0, 0, 0, 0};
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("reset u%0d busy", k), int'(busy[k]), 0);
      chk($sformatf("reset u%0d done", k), int'(done[k]), 0);
      chk($sformatf("reset u%0d found", k), int'(found[k]), 0);
      chk($sformatf("reset u%0d best_sel", k), int'(bsel[k]), 0);
      chk($sformatf("reset u%0d best_value", k), int'(bval[k]), 0);
      chk($sformatf("reset u%0d sol_count", k), int'(cnt[k]), 0);
    end
    chk("reset sol_valid", int'(i0.sol_valid), 0);
    chk("reset sol_sel", int'(i0.sol_sel), 0);
    chk("reset sol_value", int'(i0.sol_value), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      ev_sel = sel_t'(ev[i].sel);
      #1;
      chk($sformatf("eval 0x%03h value", ev[i].sel), int'(ev_v), ev[i].v);
      chk($sformatf("eval 0x%03h weight", ev[i].sel), int'(ev_w), ev[i].w);
      chk($sformatf("eval 0x%03h volume", ev[i].sel), int'(ev_u), ev[i].u);
    end
    q0.delete();
    n1 = 0;
    v3 = 0;
    sweep(3000);
    chk("A done latency", d[0], 2051);
    chk("A done latency min200", d[3], 2051);
    chk("A done arrives u1", int'(d[1] > 0), 1);
    chk("A done arrives u2", int'(d[2] > 0), 1);
    @(posedge clk); #1;
    chk("A done one cycle", int'(done[0]), 0);
    chk("A not busy in DONE", int'(busy[0]), 0);
    for (int k = 0; k < 4; k++) chk_res("A", k);
    chk_stream("A");
    chk("A u1 solutions", n1, 1);
    chk("A u1 sel", s1, 0);
    chk("A min200 sol_valid cycles", v3, 0);
    q0.delete();
    herr = 0;
    rnd = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int n = 1; n <= 12000 && !got; n++) begin
      @(posedge clk); #1;
      start = n == 500;
      if (n == 501) chk("B start ignored busy", int'(busy[0]), 1);
      if (done[0]) begin
        got = 1'b1;
        start = 1'b1;
      end
    end
    rnd = 1'b0;
    chk("B done reached", int'(got), 1);
    chk_stream("B");
    chk("B output held while stalled", herr, 0);
    chk_res("B", 0);
    q0.delete();
    @(posedge clk); #1 start = 1'b0;
    chk("C restart found", int'(found[0]), 0);
    chk("C restart count", int'(cnt[0]), 0);
    chk("C restart busy", int'(busy[0]), 1);
    repeat (999) @(posedge clk);
    #1;
    chk("C busy at cycle 1000", int'(busy[0]), 1);
    rst_n = 1'b0;
    #1;
    chk("abort busy", int'(busy[0]), 0);
    chk("abort done", int'(done[0]), 0);
    chk("abort found", int'(found[0]), 0);
    chk("abort best_sel", int'(bsel[0]), 0);
    chk("abort best_value", int'(bval[0]), 0);
    chk("abort sol_count", int'(cnt[0]), 0);
    chk("abort sol_valid", int'(i0.sol_valid), 0);
    chk("abort sol_sel", int'(i0.sol_sel), 0);
    chk("abort sol_value", int'(i0.sol_value), 0);
    chk("abort u2 sol_count", int'(cnt[2]), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    dseen = 0;
    repeat (1200) @(posedge clk);
    #1;
    chk("no done after abort", dseen, 0);
    chk("idle after abort", int'(busy[0]), 0);
    q0.delete();
    sweep(3000);
    chk("D done latency", d[0], 2051);
    chk_stream("D");
    chk_res("D", 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
